// File: rtl/seven_seg_reader_if.sv
// ---------------------------------------------------------------------------
// seven_seg_reader_if
//   Bundles the display pins watched by seven_seg_reader and its decoded
//   result valid/ready port.
//   Build macro: ERR_CNT_EN adds err_cnt (accepted-error counter).
//   Signals:
//     seg_a, seg_b  [0:6] active-low abcdefg buses (tens / ones), bit0=a
//     val           [3:0] decoded value (0 on error)
//     val_err             result is illegal / out of range
//     val_valid           result held until accepted
//     val_ready           consumer accept strobe
//     err_cnt       [7:0] (ERR_CNT_EN) accepted error results, saturating
//   Modports: master = reader side, slave = display/consumer side.
// ---------------------------------------------------------------------------
interface seven_seg_reader_if;
    logic [0:6] seg_a;
    logic [0:6] seg_b;
    logic [3:0] val;
    logic       val_err;
    logic       val_valid;
    logic       val_ready;
`ifdef ERR_CNT_EN
    logic [7:0] err_cnt;

    modport master (input seg_a, seg_b, val_ready,
                    output val, val_err, val_valid, err_cnt);
    modport slave  (output seg_a, seg_b, val_ready,
                    input val, val_err, val_valid, err_cnt);
`else
    modport master (input seg_a, seg_b, val_ready,
                    output val, val_err, val_valid);
    modport slave  (output seg_a, seg_b, val_ready,
                    input val, val_err, val_valid);
`endif
endinterface

// File: rtl/seven_seg_reader.sv
// ---------------------------------------------------------------------------
// seven_seg_reader
//   Debounces a two-digit active-low seven-segment display and decodes each
//   distinct stable pattern once into a 4-bit value on a valid/ready port.
//   Build macro: ERR_CNT_EN adds the err_cnt output/counter.
//   Parameters:
//     STABLE_CYCLES  identical samples needed before decoding (>=1)
//     BLANK_IS_ERR   1: all-blank display reports an error; 0: ignored
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   seven_seg_reader_if.master (pins in, result out)
// ---------------------------------------------------------------------------
module seven_seg_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter bit BLANK_IS_ERR  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_reader_if.master bus
);
    localparam int            CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CYCLES - 1);
    localparam logic [0:6]    BLANK   = 7'b1111111;
    localparam logic [0:6]    TENS_1  = 7'b1001111;

    typedef enum logic [1:0] {TRACK = 2'd0, EMIT = 2'd1, LOCK = 2'd2} state_e;

    // {blank, err, val}
    function automatic logic [5:0] decode(input logic [0:6] ta, input logic [0:6] ob);
        logic [3:0] o;
        logic       o_ok;
        logic       o_bl;
        logic       t_bl;
        logic       t_one;
        logic [4:0] sum;
        o    = 4'd0;
        o_ok = 1'b1;
        o_bl = 1'b0;
        case (ob)
            7'b0000001: o = 4'd0;
            7'b1001111: o = 4'd1;
            7'b0010010: o = 4'd2;
            7'b0000110: o = 4'd3;
            7'b1001100: o = 4'd4;
            7'b0100100: o = 4'd5;
            7'b0100000: o = 4'd6;
            7'b0001111: o = 4'd7;
            7'b0000000: o = 4'd8;
            7'b0000100: o = 4'd9;
            7'b1111111: o_bl = 1'b1;
            default:    o_ok = 1'b0;
        endcase
        t_bl  = (ta == BLANK);
        t_one = (ta == TENS_1);
        sum   = 5'd10 + {1'b0, o};
        if (t_bl && o_bl)
            return BLANK_IS_ERR ? 6'b010000 : 6'b100000;
        if (!(t_bl || t_one) || !o_ok || (t_one && o_bl))
            return 6'b010000;
        if (t_one)
            return (sum > 5'd15) ? 6'b010000 : {2'b00, sum[3:0]};
        return {2'b00, o};
    endfunction

    state_e        state_q, state_d;
    logic [0:6]    seg_a_q, seg_b_q;   // registered pins; all logic uses these
    logic [0:6]    cap_a_q, cap_b_q;   // pattern being debounced
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_trk;
    logic [3:0]    res_val_q;          // decoded result parked until the slot frees
    logic          res_err_q;
    logic [3:0]    val_q;
    logic          val_err_q, val_valid_q;
    logic [5:0]    samp_dec;
    logic          samp_eq, hit, slot_free;
    logic          cap_ld, res_ld, emit_ld;

    assign samp_eq   = (seg_a_q == cap_a_q) && (seg_b_q == cap_b_q);
    assign samp_dec  = decode(seg_a_q, seg_b_q);
    assign slot_free = !val_valid_q || bus.val_ready;

    // Counter as it would be after this edge in TRACK; a changed sample
    // restarts at 0, so STABLE_CYCLES=1 decodes on the load edge itself.
    assign cnt_trk = !samp_eq ? '0 : (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CW'(1);
    assign hit     = (cnt_trk == CNT_TOP);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= TRACK;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACK:   if (hit) state_d = samp_dec[5] ? LOCK : EMIT;
            EMIT:    if (slot_free) state_d = samp_eq ? LOCK : TRACK;
            LOCK:    if (!samp_eq) state_d = TRACK;
            default: state_d = TRACK;
        endcase
    end

    // FSM outputs: datapath load strobes and next counter value
    always_comb begin
        cap_ld  = 1'b0;
        res_ld  = 1'b0;
        emit_ld = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            TRACK: begin
                cap_ld = !samp_eq;
                cnt_d  = cnt_trk;
                res_ld = hit;
            end
            EMIT: begin
                // Pin changes while waiting are ignored; the new pattern is
                // picked up only once the held result has been delivered.
                emit_ld = slot_free;
                if (slot_free && !samp_eq) begin
                    cap_ld = 1'b1;
                    cnt_d  = '0;
                end
            end
            LOCK: begin
                if (!samp_eq) begin
                    cap_ld = 1'b1;
                    cnt_d  = '0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_a_q     <= BLANK;
            seg_b_q     <= BLANK;
            cap_a_q     <= BLANK;
            cap_b_q     <= BLANK;
            cnt_q       <= '0;
            res_val_q   <= 4'd0;
            res_err_q   <= 1'b0;
            val_q       <= 4'd0;
            val_err_q   <= 1'b0;
            val_valid_q <= 1'b0;
        end else begin
            seg_a_q <= bus.seg_a;
            seg_b_q <= bus.seg_b;
            cnt_q   <= cnt_d;
            if (cap_ld) begin
                cap_a_q <= seg_a_q;
                cap_b_q <= seg_b_q;
            end
            if (res_ld) begin
                res_val_q <= samp_dec[3:0];
                res_err_q <= samp_dec[4];
            end
            // Load wins over accept so back-to-back results have no bubble.
            if (emit_ld) begin
                val_q       <= res_val_q;
                val_err_q   <= res_err_q;
                val_valid_q <= 1'b1;
            end else if (val_valid_q && bus.val_ready) begin
                val_valid_q <= 1'b0;
            end
        end
    end

    assign bus.val       = val_q;
    assign bus.val_err   = val_err_q;
    assign bus.val_valid = val_valid_q;

`ifdef ERR_CNT_EN
    logic [7:0] err_cnt_q;
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= 8'd0;
        else if (val_valid_q && bus.val_ready && val_err_q && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end
    assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_seven_seg_reader.sv
module tb_seven_seg_reader;
    localparam logic [0:6] BL = 7'b1111111;
    localparam logic [0:6] T1 = 7'b1001111;
    localparam logic [0:6] D1 = 7'b1001111;
    localparam logic [0:6] D2 = 7'b0010010;
    localparam logic [0:6] D3 = 7'b0000110;
    localparam logic [0:6] D4 = 7'b1001100;
    localparam logic [0:6] D5 = 7'b0100100;
    localparam logic [0:6] D6 = 7'b0100000;
    localparam logic [0:6] D7 = 7'b0001111;
    localparam logic [0:6] D9 = 7'b0000100;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   acc_n = 0;
    int   base;
    logic [4:0] acc_log[$];   // {err, val} of every accepted result

    seven_seg_reader_if bus ();

    seven_seg_reader #(.STABLE_CYCLES(4), .BLANK_IS_ERR(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.val_valid === 1'b1 && bus.val_ready === 1'b1) begin
            acc_n++;
            acc_log.push_back({bus.val_err, bus.val});
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.seg_a     = BL;
        bus.seg_b     = BL;
        bus.val_ready = 1'b0;
        step(2);
        chk("rst_val", {28'd0, bus.val}, 0);
        chk("rst_err", {31'd0, bus.val_err}, 0);
        chk("rst_valid", {31'd0, bus.val_valid}, 0);
`ifdef ERR_CNT_EN
        chk("rst_errcnt", {24'd0, bus.err_cnt}, 0);
`endif
        rst = 1'b0;
        step(10);
        chk("blank_quiet", {31'd0, bus.val_valid}, 0);

        // 1: ones=5, tens blank; valid on edge 6, then accepted once
        bus.seg_b     = D5;
        bus.val_ready = 1'b1;
        base          = acc_n;
        step(5);
        chk("t1_not_yet", {31'd0, bus.val_valid}, 0);
        step(1);
        chk("t1_valid", {31'd0, bus.val_valid}, 1);
        chk("t1_val", {28'd0, bus.val}, 5);
        chk("t1_err", {31'd0, bus.val_err}, 0);
        step(10);
        chk("t1_once", acc_n - base, 1);
        chk("t1_low", {31'd0, bus.val_valid}, 0);

        // 2: 13 held with ready low, then exactly one accept
        bus.val_ready = 1'b0;
        bus.seg_a     = T1;
        bus.seg_b     = D3;
        base          = acc_n;
        step(20);
        chk("t2_valid", {31'd0, bus.val_valid}, 1);
        chk("t2_val", {28'd0, bus.val}, 13);
        chk("t2_noacc", acc_n - base, 0);
        bus.val_ready = 1'b1;
        step(1);
        chk("t2_drop", {31'd0, bus.val_valid}, 0);
        step(5);
        chk("t2_one_acc", acc_n - base, 1);
        chk("t2_logged", {27'd0, acc_log[acc_log.size()-1]}, 13);

        // 3: 16 is out of range -> error result
        bus.val_ready = 1'b0;
        bus.seg_b     = D6;
        step(8);
        chk("t3_valid", {31'd0, bus.val_valid}, 1);
        chk("t3_err", {31'd0, bus.val_err}, 1);
        chk("t3_val", {28'd0, bus.val}, 0);
        bus.val_ready = 1'b1;
        step(1);
        chk("t3_drop", {31'd0, bus.val_valid}, 0);
`ifdef ERR_CNT_EN
        chk("t3_errcnt", {24'd0, bus.err_cnt}, 1);
`endif

        // 4: ones=1 for STABLE-1 cycles is a glitch; only 2 reported
        bus.seg_a = BL;
        bus.seg_b = D1;
        base      = acc_n;
        step(3);
        bus.seg_b = D2;
        step(12);
        chk("t4_count", acc_n - base, 1);
        chk("t4_val", {27'd0, acc_log[acc_log.size()-1]}, 2);

        // 5: pending 7 while 9 becomes stable -> 7 then 9, no bubble
        bus.val_ready = 1'b0;
        bus.seg_b     = D7;
        base          = acc_n;
        step(8);
        chk("t5_seven", {28'd0, bus.val}, 7);
        bus.seg_b = D9;
        step(10);
        chk("t5_held", {28'd0, bus.val}, 7);
        chk("t5_held_v", {31'd0, bus.val_valid}, 1);
        bus.val_ready = 1'b1;
        step(1);
        chk("t5_b2b_v", {31'd0, bus.val_valid}, 1);
        chk("t5_nine", {28'd0, bus.val}, 9);
        step(1);
        chk("t5_drop", {31'd0, bus.val_valid}, 0);
        chk("t5_count", acc_n - base, 2);
        chk("t5_first", {27'd0, acc_log[acc_log.size()-2]}, 7);

        // 6: reset while a result is held and a new one waits in EMIT
        bus.val_ready = 1'b0;
        bus.seg_b     = D3;
        step(8);
        bus.seg_b = D4;
        step(10);
        chk("t6_pre", {31'd0, bus.val_valid}, 1);
        rst       = 1'b1;
        bus.seg_b = BL;
        step(1);
        chk("t6_val", {28'd0, bus.val}, 0);
        chk("t6_err", {31'd0, bus.val_err}, 0);
        chk("t6_valid", {31'd0, bus.val_valid}, 0);
`ifdef ERR_CNT_EN
        chk("t6_errcnt", {24'd0, bus.err_cnt}, 0);
`endif
        rst           = 1'b0;
        bus.val_ready = 1'b1;
        base          = acc_n;
        step(15);
        chk("t6_quiet", {31'd0, bus.val_valid}, 0);
        chk("t6_noacc", acc_n - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
